pdm_stereo_tx: RTL and testbench

- Stereo PDM transmitter: the encode side of the PDM link whose bench-side decoder recovers 16-bit left/right audio.
- Accepts signed 16-bit sample pairs over a valid/ready handshake and double-buffers them.
- Runs a first-order sigma-delta modulator per channel and drives complementary PDM outputs toward the speaker drivers.
- Includes a soft-start/soft-stop ramp state machine to suppress pops on enable/disable.

---
 rtl/pdm_tx_pkg.sv | 14 +
 rtl/pdm_mod_core.sv | 69 ++++++
 rtl/pdm_stereo_tx.sv | 138 +++++++++++++
 tb/tb_pdm_stereo_tx.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pdm_tx_pkg.sv
// pdm_tx_pkg: shared state type, mid-scale constant and offset-binary helper for the PDM transmitter
package pdm_tx_pkg;

    typedef enum logic [1:0] {IDLE, RAMP_UP, RUN, RAMP_DN} state_t;

    localparam int DEF_DATA_W = 16;
    localparam int MID_SCALE  = 1 << (DEF_DATA_W - 1);

    // Two's complement to offset binary: flip the sign bit of a w-bit value.
    function automatic logic [31:0] to_offset(input logic [31:0] s, input int w);
        return s ^ (32'd1 << (w - 1));
    endfunction

endpackage

// File: rtl/pdm_mod_core.sv
// pdm_mod_core: one-channel sigma-delta modulator turning a duty code into a PDM bit
//   clk, rst   : clock, synchronous active-high reset
//   tick       : advance the modulator by one PDM bit
//   clr        : hold integrators and outputs at their cleared values
//   code       : unsigned duty code, code/2^DATA_W is the mean density of ones
//   pdm, pdm_n : registered bitstream and its complement
//   PDM_TX_2ND_ORDER_EN selects a second-order loop instead of the first-order accumulator
module pdm_mod_core import pdm_tx_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              clr,
    input  logic [DATA_W-1:0] code,
    output logic              pdm,
    output logic              pdm_n
);

`ifdef PDM_TX_2ND_ORDER_EN
    localparam int W1 = DATA_W + 3;
    localparam int W2 = DATA_W + 5;
    localparam logic signed [W1-1:0] MID = {4'b0001, {(DATA_W-1){1'b0}}};

    logic signed [W1-1:0] i1, i1_nxt, x, fb;
    logic signed [W2-1:0] i2, i2_nxt;

    // Error feedback is the quantised output mapped back to +/- mid-scale.
    always_comb begin
        x      = $signed({3'b000, code}) - MID;
        fb     = pdm ? MID : -MID;
        i1_nxt = i1 + x - fb;
        i2_nxt = i2 + {{2{i1_nxt[W1-1]}}, i1_nxt} - {{2{fb[W1-1]}}, fb};
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            i1    <= '0;
            i2    <= '0;
            pdm   <= 1'b0;
            pdm_n <= 1'b1;
        end else if (tick) begin
            i1    <= i1_nxt;
            i2    <= i2_nxt;
            pdm   <= !i2_nxt[W2-1];
            pdm_n <= i2_nxt[W2-1];
        end
    end
`else
    logic [DATA_W-1:0] acc;
    logic [DATA_W:0]   sum;

    // The carry out of the wrapped accumulator is the output bit.
    assign sum = {1'b0, acc} + {1'b0, code};

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc   <= '0;
            pdm   <= 1'b0;
            pdm_n <= 1'b1;
        end else if (tick) begin
            acc   <= sum[DATA_W-1:0];
            pdm   <= sum[DATA_W];
            pdm_n <= !sum[DATA_W];
        end
    end
`endif

endmodule

// File: rtl/pdm_stereo_tx.sv
// pdm_stereo_tx: stereo PDM transmitter with double-buffered sample input and pop-free ramping
//   clk, rst              : clock, synchronous active-high reset
//   en                    : ramp up and run when high, ramp down to idle when low
//   lft_smpl, rght_smpl   : signed sample pair, accepted when smpl_vld && smpl_rdy
//   smpl_vld, smpl_rdy    : input handshake; smpl_rdy is the registered pending-empty flag
//   lft_PDM(_n), rght_PDM(_n) : complementary PDM outputs per channel
//   running               : high only while modulating live audio
//   PDM_TX_2ND_ORDER_EN selects second-order modulators (see pdm_mod_core)
module pdm_stereo_tx import pdm_tx_pkg::*; #(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int PDM_DIV   = 2,
    parameter int RAMP_STEP = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] lft_smpl,
    input  logic [DATA_W-1:0] rght_smpl,
    input  logic              smpl_vld,
    output logic              smpl_rdy,
    output logic              lft_PDM,
    output logic              lft_PDM_n,
    output logic              rght_PDM,
    output logic              rght_PDM_n,
    output logic              running
);

    localparam int CW = PDM_DIV > 1 ? $clog2(PDM_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(PDM_DIV - 1);
    localparam logic [DATA_W-1:0] MID = (DATA_W == DEF_DATA_W) ? DATA_W'(MID_SCALE)
                                                                : {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] STEP = DATA_W'(RAMP_STEP);

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt;
    logic              tick, accept, xfer, pend_full, idle;
    logic [DATA_W-1:0] ramp, ramp_nxt;
    logic [DATA_W-1:0] pend_l, pend_r, act_l, act_r, src_l, src_r, code_l, code_r;

    assign tick     = cnt == DIV_LAST;
    assign accept   = smpl_vld && !pend_full;
    assign xfer     = tick && pend_full;
    assign smpl_rdy = !pend_full;
    assign running  = state == RUN;
    assign idle     = state == IDLE;

    // Accept only into an empty pending slot, so accept and transfer never collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            pend_full <= 1'b0;
            pend_l    <= '0;
            pend_r    <= '0;
            act_l     <= '0;
            act_r     <= '0;
        end else begin
            cnt       <= tick ? '0 : cnt + 1'b1;
            pend_full <= accept || (pend_full && !tick);
            if (accept) begin
                pend_l <= lft_smpl;
                pend_r <= rght_smpl;
            end
            if (xfer) begin
                act_l <= pend_l;
                act_r <= pend_r;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ramp  <= '0;
        end else begin
            state <= state_nxt;
            ramp  <= ramp_nxt;
        end
    end

    // en is honoured on any cycle; ramp position only moves on ticks.
    always_comb begin
        state_nxt = state;
        ramp_nxt  = ramp;
        case (state)
            IDLE:
                if (en) begin
                    state_nxt = RAMP_UP;
                    ramp_nxt  = '0;
                end
            RAMP_UP:
                if (!en) state_nxt = RAMP_DN;
                else if (tick) begin
                    state_nxt = ramp >= MID - STEP ? RUN : RAMP_UP;
                    ramp_nxt  = ramp >= MID - STEP ? MID : ramp + STEP;
                end
            RUN:
                if (!en) begin
                    state_nxt = RAMP_DN;
                    ramp_nxt  = MID;
                end
            RAMP_DN:
                if (en) state_nxt = RAMP_UP;
                else if (tick) begin
                    state_nxt = ramp <= STEP ? IDLE : RAMP_DN;
                    ramp_nxt  = ramp <= STEP ? '0 : ramp - STEP;
                end
        endcase
    end

    // In RUN a pair transferring on this tick is modulated on this same tick.
    always_comb begin
        src_l  = xfer ? pend_l : act_l;
        src_r  = xfer ? pend_r : act_r;
        code_l = idle ? '0 : running ? DATA_W'(to_offset(32'(src_l), DATA_W)) : ramp;
        code_r = idle ? '0 : running ? DATA_W'(to_offset(32'(src_r), DATA_W)) : ramp;
    end

    pdm_mod_core #(.DATA_W(DATA_W)) u_lft (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick),
        .clr   (idle),
        .code  (code_l),
        .pdm   (lft_PDM),
        .pdm_n (lft_PDM_n)
    );

    pdm_mod_core #(.DATA_W(DATA_W)) u_rght (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick),
        .clr   (idle),
        .code  (code_r),
        .pdm   (rght_PDM),
        .pdm_n (rght_PDM_n)
    );

endmodule

// File: tb/tb_pdm_stereo_tx.sv
// tb_pdm_stereo_tx: directed and randomised checks of pdm_stereo_tx against duty-cycle arithmetic
module tb_pdm_stereo_tx;

    logic        clk = 1'b0, rst = 1'b1, en = 1'b0, smpl_vld = 1'b0;
    logic [15:0] lft_smpl = '0, rght_smpl = '0;
    logic        smpl_rdy, lft_PDM, lft_PDM_n, rght_PDM, rght_PDM_n, running;
    int          errors = 0, checks = 0;

    localparam logic [5:0] RST_OUT = 6'b010110; // {l, l_n, r, r_n, rdy, running}

    always #5 clk = ~clk;

    pdm_stereo_tx #(.DATA_W(16), .PDM_DIV(2), .RAMP_STEP(256)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .lft_smpl   (lft_smpl),
        .rght_smpl  (rght_smpl),
        .smpl_vld   (smpl_vld),
        .smpl_rdy   (smpl_rdy),
        .lft_PDM    (lft_PDM),
        .lft_PDM_n  (lft_PDM_n),
        .rght_PDM   (rght_PDM),
        .rght_PDM_n (rght_PDM_n),
        .running    (running)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [5:0] outs();
        return {lft_PDM, lft_PDM_n, rght_PDM, rght_PDM_n, smpl_rdy, running};
    endfunction

    // Offset-binary duty code of a signed sample.
    function automatic longint ucode(input logic [15:0] s);
        return longint'(s ^ 16'h8000);
    endfunction

    // Sum of ramp-down codes over the 32-tick window k (codes start at mid-scale, fall by 256 per tick).
    function automatic longint ramp_dn_sum(input int k);
        longint s = 0;
        for (int j = 32 * k; j < 32 * k + 32; j++) s += (j < 128) ? longint'(32768 - 256 * j) : 0;
        return s;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input longint obs, input longint lo, input longint hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // A first-order stream with constant code over n ticks holds floor or ceil of n*code/2^16 ones.
    task automatic chk_duty(input string tag, input int ones, input longint u, input int n);
        longint s = u * n;
        chk_rng(tag, ones, s / 65536, (s % 65536 == 0) ? s / 65536 : s / 65536 + 1);
    endtask

    task automatic send(input logic [15:0] l, input logic [15:0] r);
        int k = 0;
        lft_smpl = l;
        rght_smpl = r;
        smpl_vld = 1'b1;
        while (!smpl_rdy && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk_rng("send_wait", k, 0, 49);
        @(negedge clk);
        smpl_vld = 1'b0;
    endtask

    // Outputs hold for one tick (2 clocks), so sampling every second negedge sees each bit once.
    task automatic measure(input int n, output int ones_l, output int ones_r, output int tog_l, output int bad_n);
        logic prev = 1'b0;
        ones_l = 0; ones_r = 0; tog_l = 0; bad_n = 0;
        for (int i = 0; i < n; i++) begin
            repeat (2) @(negedge clk);
            ones_l += int'(lft_PDM);
            ones_r += int'(rght_PDM);
            if (i > 0 && lft_PDM != prev) tog_l++;
            prev = lft_PDM;
            if ($isunknown({lft_PDM, rght_PDM}) || lft_PDM_n !== ~lft_PDM || rght_PDM_n !== ~rght_PDM) bad_n++;
        end
    endtask

    task automatic wait_running(input string tag, input int lo, input int hi);
        int c = 0;
        while (!running && c < 1000) begin
            @(negedge clk);
            c++;
        end
        chk_rng(tag, c, lo, hi);
    endtask

    initial begin
        int ol, orr, tg, bn, c, bad;
        int w[4];
        logic [15:0] a, b;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", outs(), RST_OUT);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (outs() !== RST_OUT) bad++;
        end
        chk("idle_hold", bad, 0);

        en = 1'b1;
        wait_running("ramp_up_cycles", 253, 259);

        send(16'h4000, 16'h8000);
        repeat (6) @(negedge clk);
        measure(64, ol, orr, tg, bn);
        chk("dc_l_4000", ol, 48);
        chk("dc_r_8000", orr, 0);
        chk("compl_1", bn, 0);

        send(16'h0000, 16'h4000);
        repeat (6) @(negedge clk);
        measure(64, ol, orr, tg, bn);
        chk("dc_l_0000_ones", ol, 32);
        chk("dc_l_0000_alt", tg, 63);
        chk("dc_r_4000", orr, 48);
        chk("compl_2", bn, 0);

        send(16'h7FFF, 16'h8001);
        repeat (6) @(negedge clk);
        measure(256, ol, orr, tg, bn);
        chk_duty("dc_l_7fff", ol, ucode(16'h7FFF), 256);
        chk_duty("dc_r_8001", orr, ucode(16'h8001), 256);

        // Codes that are multiples of 1024 give an exact count over 64 ticks.
        for (int i = 0; i < 4; i++) begin
            a = 16'($urandom) & 16'hFC00;
            b = 16'($urandom) & 16'hFC00;
            send(a, b);
            repeat (6) @(negedge clk);
            measure(64, ol, orr, tg, bn);
            chk("rnd_exact_l", ol, ucode(a) * 64 / 65536);
            chk("rnd_exact_r", orr, ucode(b) * 64 / 65536);
            chk("rnd_exact_compl", bn, 0);
        end
        for (int i = 0; i < 3; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            send(a, b);
            repeat (6) @(negedge clk);
            measure(256, ol, orr, tg, bn);
            chk_duty("rnd_any_l", ol, ucode(a), 256);
            chk_duty("rnd_any_r", orr, ucode(b), 256);
        end

        // Ramp down from a 50% stream: density falls in steps of about 4 ones per 32 ticks.
        send(16'h0000, 16'h0000);
        repeat (6) @(negedge clk);
        en = 1'b0;
        @(posedge clk);
        #1;
        chk("run_fall", running, 1'b0);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            measure(32, w[k], orr, tg, bn);
            chk_rng("ramp_dn_win", w[k], ramp_dn_sum(k) / 65536 - 2, ramp_dn_sum(k) / 65536 + 2);
            chk("ramp_dn_lr_equal", orr, w[k]);
            if (k > 0) chk("ramp_dn_mono", w[k] < w[k-1], 1'b1);
        end
        repeat (10) @(negedge clk);
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if ({lft_PDM, lft_PDM_n, rght_PDM, rght_PDM_n, running} !== 5'b01010) bad++;
        end
        chk("idle_after_ramp_dn", bad, 0);

        // Zero-duty pairs leave the accumulator frozen at the nonzero residue of the ramp, so a
        // single tick of full-scale A must emit exactly one 1 per channel and nothing afterwards.
        send(16'h8000, 16'h8000);
        en = 1'b1;
        wait_running("ramp_up2_cycles", 253, 259);
        repeat (8) @(negedge clk);
        fork
            measure(60, ol, orr, tg, bn);
            begin
                lft_smpl = 16'h7FFF;
                rght_smpl = 16'h7FFF;
                smpl_vld = 1'b1;
                @(posedge clk);
                #1;
                chk("bp_rdy_drop", smpl_rdy, 1'b0);
                lft_smpl = 16'h8000;
                rght_smpl = 16'h8000;
                c = 0;
                while (!smpl_rdy && c < 10) begin
                    @(posedge clk);
                    #1;
                    c++;
                end
                chk_rng("bp_rdy_low_len", c, 1, 2);
                @(posedge clk);
                #1;
                chk("bp_second_accept", smpl_rdy, 1'b0);
                smpl_vld = 1'b0;
            end
        join
        chk("bp_first_pair_l", ol, 1);
        chk("bp_first_pair_r", orr, 1);
        measure(64, ol, orr, tg, bn);
        chk("bp_second_pair_l", ol, 0);
        chk("bp_second_pair_r", orr, 0);

        // Re-enabling halfway down resumes from mid-ramp, so RUN returns after ~64 ticks.
        en = 1'b0;
        repeat (128) @(negedge clk);
        en = 1'b1;
        wait_running("reramp_cycles", 122, 134);

        repeat (5) @(negedge clk);
        lft_smpl = 16'h1234;
        rght_smpl = 16'hABCD;
        smpl_vld = 1'b1;
        @(posedge clk);
        #1;
        chk("mr_pend_full", smpl_rdy, 1'b0);
        @(negedge clk);
        smpl_vld = 1'b0;
        rst = 1'b1;
        en = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_reset_outs", outs(), RST_OUT);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("post_reset_idle", outs(), RST_OUT);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
